// File: rtl/fp_align_stage_seq.sv
// Lane-serialising front stage of the FP pipeline: holds one operand vector and emits
// add/sub alignment plus multiply exponent/sign for LANES_PER_CYCLE lanes per beat.
module fp_align_stage_seq #(
  parameter int NUM_LANES       = 16,
  parameter int LANES_PER_CYCLE = 4,
  parameter int EXP_WIDTH       = 8,
  parameter int SIG_WIDTH       = 23,
  parameter int TAG_WIDTH       = 4,
  parameter int SKIP_MASKED     = 1,
  localparam int FW = 1 + EXP_WIDTH + SIG_WIDTH,
  localparam int L  = LANES_PER_CYCLE,
  localparam int G  = NUM_LANES / LANES_PER_CYCLE,
  localparam int GW = (G > 1) ? $clog2(G) : 1,
  localparam int MW = SIG_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_op,
  input  logic [NUM_LANES*FW-1:0]    in_operand1,
  input  logic [NUM_LANES*FW-1:0]    in_operand2,
  input  logic [NUM_LANES-1:0]       in_mask,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [GW-1:0]              out_group,
  output logic                       out_last,
  output logic [TAG_WIDTH-1:0]       out_tag,
  output logic [L-1:0]               out_mask,
  output logic [L*MW-1:0]            out_sig_le,
  output logic [L*MW-1:0]            out_sig_se,
  output logic [L*6-1:0]             out_align_shift,
  output logic [L*EXP_WIDTH-1:0]     out_add_exponent,
  output logic [L-1:0]               out_logical_subtract,
  output logic [L-1:0]               out_add_sign,
  output logic [L*EXP_WIDTH-1:0]     out_mul_exponent,
  output logic [L-1:0]               out_mul_sign,
  output logic [L-1:0]               out_mul_underflow,
  output logic [L-1:0]               out_is_nan,
  output logic [L-1:0]               out_is_inf
);

  // state | meaning
  // IDLE  | no vector held, in_ready high
  // BUSY  | vector held, a beat is on the output (out_valid high)

  localparam int BIAS  = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int SHMAX = SIG_WIDTH + 4;
  localparam int CW    = EXP_WIDTH + 7;
  localparam int GM1   = G - 1;

  localparam logic [GW-1:0]        LAST_G  = GM1[GW-1:0];
  localparam logic [EXP_WIDTH+1:0] BIAS_X  = BIAS[EXP_WIDTH+1:0];
  localparam logic [CW-1:0]        SHMAX_X = SHMAX[CW-1:0];
  localparam logic [5:0]           SHMAX_6 = SHMAX[5:0];

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [MW-1:0]        sig_le;
    logic [MW-1:0]        sig_se;
    logic [5:0]           shift;
    logic [EXP_WIDTH-1:0] add_exp;
    logic                 lsub;
    logic                 add_sign;
    logic [EXP_WIDTH-1:0] mul_exp;
    logic                 mul_sign;
    logic                 mul_uf;
    logic                 is_nan;
    logic                 is_inf;
  } lane_res_t;

  function automatic lane_res_t lane_calc(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                          input logic [1:0] op);
    lane_res_t            r;
    logic [EXP_WIDTH-1:0] e1, e2, diff;
    logic [SIG_WIDTH-1:0] f1, f2;
    logic [MW-1:0]        m1, m2;
    logic [EXP_WIDTH+1:0] msum;
    logic [CW-1:0]        diff_x;
    logic                 is_sub, is_mul, op1_larger;
    logic                 inf1, inf2, nan1, nan2, zero1, zero2;
    e1 = a[FW-2 -: EXP_WIDTH];
    e2 = b[FW-2 -: EXP_WIDTH];
    f1 = a[SIG_WIDTH-1:0];
    f2 = b[SIG_WIDTH-1:0];
    m1 = {|e1, f1};
    m2 = {|e2, f2};
    is_sub = (op == 2'd1) || (op == 2'd2);
    is_mul = (op == 2'd3);
    inf1  = (&e1) && (f1 == '0);
    inf2  = (&e2) && (f2 == '0);
    nan1  = (&e1) && (f1 != '0);
    nan2  = (&e2) && (f2 != '0);
    zero1 = (e1 == '0) && (f1 == '0);
    zero2 = (e2 == '0) && (f2 == '0);
    // equal magnitudes keep op1 in the larger slot
    op1_larger = (e1 > e2) || ((e1 == e2) && (m1 >= m2));
    r.sig_le   = op1_larger ? m1 : m2;
    r.sig_se   = op1_larger ? m2 : m1;
    r.add_exp  = op1_larger ? e1 : e2;
    r.add_sign = op1_larger ? a[FW-1] : (b[FW-1] ^ is_sub);
    diff       = op1_larger ? (e1 - e2) : (e2 - e1);
    diff_x     = {{7{1'b0}}, diff};
    r.shift    = (diff_x > SHMAX_X) ? SHMAX_6 : diff_x[5:0];
    r.lsub     = a[FW-1] ^ b[FW-1] ^ is_sub;
    // two guard bits: bit EXP_WIDTH is overflow carry, top bit goes negative on underflow
    msum       = {2'b00, e1} + {2'b00, e2} - BIAS_X;
    r.mul_exp  = msum[EXP_WIDTH-1:0];
    r.mul_sign = a[FW-1] ^ b[FW-1];
    r.mul_uf   = msum[EXP_WIDTH+1];
    if (is_mul) begin
      r.is_nan = nan1 || nan2 || (inf1 && zero2) || (inf2 && zero1);
    end else begin
      r.is_nan = nan1 || nan2 || (inf1 && inf2 && r.lsub);
    end
    r.is_inf = !r.is_nan &&
               (inf1 || inf2 || (is_mul && msum[EXP_WIDTH] && !msum[EXP_WIDTH+1]));
    return r;
  endfunction

  // Lowest emitted group at or above start; the last group is always emitted.
  function automatic logic [GW-1:0] find_group(input logic [NUM_LANES-1:0] m, input int start);
    logic [GW-1:0] g_sel;
    g_sel = LAST_G;
    for (int g = G - 1; g >= 0; g--) begin
      if ((g >= start) && ((SKIP_MASKED == 0) || (m[g*L +: L] != '0))) begin
        g_sel = g[GW-1:0];
      end
    end
    return g_sel;
  endfunction

  state_t                  state;
  logic [NUM_LANES*FW-1:0] op1_q, op2_q;
  logic [NUM_LANES-1:0]    mask_q;
  logic [1:0]              op_q;

  logic                    accept, out_fire;
  logic [NUM_LANES*FW-1:0] src_op1, src_op2;
  logic [NUM_LANES-1:0]    src_mask;
  logic [1:0]              src_op;
  logic [GW-1:0]           nxt_group;
  logic [L-1:0]            nxt_mask;
  lane_res_t               nxt_lane [L];

  assign out_fire = out_valid && out_ready;
  assign in_ready = (state == IDLE) || (out_fire && out_last);
  assign accept   = in_valid && in_ready;

  // On accept the first beat is built straight from the inputs to keep latency at one cycle.
  always_comb begin
    src_op1   = accept ? in_operand1 : op1_q;
    src_op2   = accept ? in_operand2 : op2_q;
    src_mask  = accept ? in_mask : mask_q;
    src_op    = accept ? in_op : op_q;
    nxt_group = accept ? find_group(in_mask, 0) : find_group(mask_q, int'(out_group) + 1);
    nxt_mask  = src_mask[int'(nxt_group)*L +: L];
    for (int l = 0; l < L; l++) begin
      nxt_lane[l] = lane_calc(src_op1[(int'(nxt_group)*L + l)*FW +: FW],
                              src_op2[(int'(nxt_group)*L + l)*FW +: FW], src_op);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      op1_q                <= '0;
      op2_q                <= '0;
      mask_q               <= '0;
      op_q                 <= '0;
      out_valid            <= 1'b0;
      out_group            <= '0;
      out_last             <= 1'b0;
      out_tag              <= '0;
      out_mask             <= '0;
      out_sig_le           <= '0;
      out_sig_se           <= '0;
      out_align_shift      <= '0;
      out_add_exponent     <= '0;
      out_logical_subtract <= '0;
      out_add_sign         <= '0;
      out_mul_exponent     <= '0;
      out_mul_sign         <= '0;
      out_mul_underflow    <= '0;
      out_is_nan           <= '0;
      out_is_inf           <= '0;
    end else begin
      if (accept) begin
        state   <= BUSY;
        op1_q   <= in_operand1;
        op2_q   <= in_operand2;
        mask_q  <= in_mask;
        op_q    <= in_op;
        out_tag <= in_tag;
      end else if (out_fire && out_last) begin
        state <= IDLE;
      end

      if (accept || (out_fire && !out_last)) begin
        out_valid <= 1'b1;
        out_group <= nxt_group;
        out_last  <= (nxt_group == LAST_G);
        out_mask  <= nxt_mask;
        for (int l = 0; l < L; l++) begin
          out_sig_le[l*MW +: MW]                  <= nxt_lane[l].sig_le;
          out_sig_se[l*MW +: MW]                  <= nxt_lane[l].sig_se;
          out_align_shift[l*6 +: 6]               <= nxt_lane[l].shift;
          out_add_exponent[l*EXP_WIDTH +: EXP_WIDTH] <= nxt_lane[l].add_exp;
          out_logical_subtract[l]                 <= nxt_lane[l].lsub;
          out_add_sign[l]                         <= nxt_lane[l].add_sign;
          out_mul_exponent[l*EXP_WIDTH +: EXP_WIDTH] <= nxt_lane[l].mul_exp;
          out_mul_sign[l]                         <= nxt_lane[l].mul_sign;
          out_mul_underflow[l]                    <= nxt_lane[l].mul_uf;
          out_is_nan[l]                           <= nxt_lane[l].is_nan;
          out_is_inf[l]                           <= nxt_lane[l].is_inf;
        end
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_stage_seq.sv
// Scoreboard bench for fp_align_stage_seq: a plain-arithmetic lane model queues expected
// beats at accept time; a negedge monitor pops and compares each handshaken beat.
module tb_fp_align_stage_seq;
  localparam int NL = 16, L = 4, G = 4, FW = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_op = '0;
  logic [NL*FW-1:0]  in_operand1 = '0, in_operand2 = '0;
  logic [NL-1:0]     in_mask = '0;
  logic [3:0]        in_tag = '0;
  logic              out_valid, out_ready = 1'b0, out_last;
  logic [1:0]        out_group;
  logic [3:0]        out_tag, out_mask;
  logic [L*24-1:0]   out_sig_le, out_sig_se;
  logic [L*6-1:0]    out_align_shift;
  logic [L*8-1:0]    out_add_exponent, out_mul_exponent;
  logic [L-1:0]      out_logical_subtract, out_add_sign, out_mul_sign, out_mul_underflow;
  logic [L-1:0]      out_is_nan, out_is_inf;

  fp_align_stage_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_operand1(in_operand1), .in_operand2(in_operand2), .in_mask(in_mask), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_group(out_group), .out_last(out_last),
    .out_tag(out_tag), .out_mask(out_mask), .out_sig_le(out_sig_le), .out_sig_se(out_sig_se),
    .out_align_shift(out_align_shift), .out_add_exponent(out_add_exponent),
    .out_logical_subtract(out_logical_subtract), .out_add_sign(out_add_sign),
    .out_mul_exponent(out_mul_exponent), .out_mul_sign(out_mul_sign),
    .out_mul_underflow(out_mul_underflow), .out_is_nan(out_is_nan), .out_is_inf(out_is_inf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] le, se;
    logic [5:0]  shift;
    logic [7:0]  aexp, mexp;
    logic        lsub, asign, msign, uf, nan, inf;
  } lane_t;

  typedef struct {
    int          grp;
    logic        last;
    logic [3:0]  tag, mask;
    logic [95:0] le, se;
    logic [23:0] shift;
    logic [31:0] aexp, mexp;
    logic [3:0]  lsub, asign, msign, uf, nan, inf;
  } beat_t;

  int          checks = 0, errors = 0, cycle = 0, beats_seen = 0, last_accept = 0;
  bit          rand_ready = 0;
  beat_t       exp_q[$];
  int          beat_cycles[$];
  beat_t       mon_e;
  logic [31:0] v1[NL], v2[NL];

  always @(posedge clk) cycle++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cycle);
    end
  endtask

  function automatic lane_t model_lane(input logic [31:0] a, input logic [31:0] b, input int op);
    lane_t r;
    int    e1, e2, f1, f2, m1, m2, d, sum;
    bit    sub, mul, big, inf1, inf2, nan1, nan2, z1, z2;
    e1 = int'(a[30:23]); e2 = int'(b[30:23]);
    f1 = int'(a[22:0]);  f2 = int'(b[22:0]);
    m1 = f1 + ((e1 != 0) ? 8388608 : 0);
    m2 = f2 + ((e2 != 0) ? 8388608 : 0);
    sub = (op == 1) || (op == 2);
    mul = (op == 3);
    big = (e1 > e2) || ((e1 == e2) && (m1 >= m2));
    r.le    = 24'(big ? m1 : m2);
    r.se    = 24'(big ? m2 : m1);
    r.aexp  = 8'(big ? e1 : e2);
    r.asign = big ? a[31] : (b[31] ^ sub);
    d = (e1 > e2) ? e1 - e2 : e2 - e1;
    r.shift = 6'((d > 27) ? 27 : d);
    r.lsub  = a[31] ^ b[31] ^ sub;
    sum     = e1 + e2 - 127;
    r.mexp  = 8'(sum);
    r.uf    = (sum < 0);
    r.msign = a[31] ^ b[31];
    inf1 = (e1 == 255) && (f1 == 0); nan1 = (e1 == 255) && (f1 != 0); z1 = (e1 == 0) && (f1 == 0);
    inf2 = (e2 == 255) && (f2 == 0); nan2 = (e2 == 255) && (f2 != 0); z2 = (e2 == 0) && (f2 == 0);
    if (mul) r.nan = nan1 || nan2 || (inf1 && z2) || (inf2 && z1);
    else     r.nan = nan1 || nan2 || (inf1 && inf2 && r.lsub);
    r.inf = !r.nan && (inf1 || inf2 || (mul && sum >= 256));
    return r;
  endfunction

  task automatic push_expected(input logic [1:0] op, input logic [15:0] mask, input logic [3:0] tag);
    beat_t b;
    lane_t r;
    for (int g = 0; g < G; g++) begin
      if (mask[g*L +: L] == 4'h0 && g != G - 1) continue;
      b.grp = g; b.last = (g == G - 1); b.tag = tag; b.mask = mask[g*L +: L];
      for (int l = 0; l < L; l++) begin
        r = model_lane(v1[g*L + l], v2[g*L + l], int'(op));
        b.le[l*24 +: 24] = r.le;     b.se[l*24 +: 24] = r.se;
        b.shift[l*6 +: 6] = r.shift; b.aexp[l*8 +: 8] = r.aexp;
        b.mexp[l*8 +: 8] = r.mexp;   b.lsub[l] = r.lsub;
        b.asign[l] = r.asign;        b.msign[l] = r.msign;
        b.uf[l] = r.uf;              b.nan[l] = r.nan;
        b.inf[l] = r.inf;
      end
      exp_q.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got group %0d, expected no beat (cycle %0d)", out_group, cycle);
      end else begin
        mon_e = exp_q.pop_front();
        chk("group", 128'(out_group), 128'(mon_e.grp));
        chk("last", 128'(out_last), 128'(mon_e.last));
        chk("tag", 128'(out_tag), 128'(mon_e.tag));
        chk("mask", 128'(out_mask), 128'(mon_e.mask));
        chk("sig_le", 128'(out_sig_le), 128'(mon_e.le));
        chk("sig_se", 128'(out_sig_se), 128'(mon_e.se));
        chk("align_shift", 128'(out_align_shift), 128'(mon_e.shift));
        chk("add_exponent", 128'(out_add_exponent), 128'(mon_e.aexp));
        chk("logical_subtract", 128'(out_logical_subtract), 128'(mon_e.lsub));
        chk("add_sign", 128'(out_add_sign), 128'(mon_e.asign));
        chk("mul_exponent", 128'(out_mul_exponent), 128'(mon_e.mexp));
        chk("mul_sign", 128'(out_mul_sign), 128'(mon_e.msign));
        chk("mul_underflow", 128'(out_mul_underflow), 128'(mon_e.uf));
        chk("is_nan", 128'(out_is_nan), 128'(mon_e.nan));
        chk("is_inf", 128'(out_is_inf), 128'(mon_e.inf));
        beats_seen++;
        beat_cycles.push_back(cycle);
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic logic [31:0] gen_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[30:0] = '0;
      1: begin r[30:23] = 8'hFF; r[22:0] = '0; end
      2: r[30:23] = 8'hFF;
      3: r[30:23] = 8'h00;
      4, 5: r[30:23] = 8'(110 + $urandom_range(0, 40));
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] gen_mask();
    logic [15:0] m;
    m = '0;
    for (int g = 0; g < G; g++) begin
      case ($urandom_range(0, 2))
        0: m[g*L +: L] = 4'h0;
        1: m[g*L +: L] = 4'hF;
        default: m[g*L +: L] = 4'($urandom);
      endcase
    end
    return m;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < NL; i++) begin v1[i] = gen_op(); v2[i] = gen_op(); end
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] mask, input logic [3:0] tag);
    int n;
    bit acc;
    n = 0; acc = 0;
    for (int i = 0; i < NL; i++) begin
      in_operand1[i*FW +: FW] = v1[i];
      in_operand2[i*FW +: FW] = v2[i];
    end
    in_op = op; in_mask = mask; in_tag = tag; in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        last_accept = cycle;
        push_expected(op, mask, tag);
      end
      @(posedge clk);
      n++;
      if (!acc && n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got no in_ready, expected accept within 200 cycles");
        break;
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 128'(n >= 500), 128'(0));
  endtask

  function automatic logic [315:0] outs();
    return {out_valid, out_group, out_last, out_tag, out_mask, out_sig_le, out_sig_se,
            out_align_shift, out_add_exponent, out_mul_exponent, out_logical_subtract,
            out_add_sign, out_mul_sign, out_mul_underflow, out_is_nan, out_is_inf};
  endfunction

  logic [315:0] snap;
  int           bs, acc_a, okc;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected completion within 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_last", 128'(out_last), 128'(0));
    chk("reset_out_group", 128'(out_group), 128'(0));
    chk("reset_sig_le", 128'(out_sig_le), 128'(0));
    chk("reset_mul_exponent", 128'(out_mul_exponent), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    reset = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // add 1.0 + 2.0 on lane 0
    fill_rand(); v1[0] = 32'h3F800000; v2[0] = 32'h40000000;
    bs = beats_seen;
    send(2'd0, 16'hFFFF, 4'h3);
    @(negedge clk);
    chk("t1_group", 128'(out_group), 128'(0));
    chk("t1_sig_le", 128'(out_sig_le[23:0]), 128'(24'h800000));
    chk("t1_sig_se", 128'(out_sig_se[23:0]), 128'(24'h800000));
    chk("t1_shift", 128'(out_align_shift[5:0]), 128'(1));
    chk("t1_add_exp", 128'(out_add_exponent[7:0]), 128'(8'h80));
    chk("t1_sign_lsub", 128'({out_add_sign[0], out_logical_subtract[0]}), 128'(0));
    drain();
    chk("t1_beats", 128'(beats_seen - bs), 128'(4));

    // sub tie
    fill_rand(); v1[0] = 32'h40400000; v2[0] = 32'h40400000;
    send(2'd1, 16'hFFFF, 4'h5);
    @(negedge clk);
    chk("t2_sig_le", 128'(out_sig_le[23:0]), 128'(24'hC00000));
    chk("t2_lsub", 128'(out_logical_subtract[0]), 128'(1));
    chk("t2_add_sign", 128'(out_add_sign[0]), 128'(0));
    chk("t2_shift", 128'(out_align_shift[5:0]), 128'(0));
    drain();

    // +inf + -inf
    fill_rand(); v1[0] = 32'h7F800000; v2[0] = 32'hFF800000;
    send(2'd0, 16'hFFFF, 4'h6);
    @(negedge clk);
    chk("t3_nan", 128'(out_is_nan[0]), 128'(1));
    chk("t3_inf", 128'(out_is_inf[0]), 128'(0));
    drain();

    // multiply specials
    fill_rand();
    v1[0] = 32'h7F800000; v2[0] = 32'h00000000;
    v1[1] = 32'h7F000000; v2[1] = 32'h7F000000;
    v1[2] = 32'h3F800000; v2[2] = 32'h3F800000;
    send(2'd3, 16'hFFFF, 4'h7);
    @(negedge clk);
    chk("t4_inf_times_zero_nan", 128'(out_is_nan[0]), 128'(1));
    chk("t4_overflow_inf", 128'(out_is_inf[1]), 128'(1));
    chk("t4_one_mexp", 128'(out_mul_exponent[23:16]), 128'(8'h7F));
    chk("t4_one_uf", 128'(out_mul_underflow[2]), 128'(0));
    drain();

    // shift saturation
    fill_rand(); v1[0] = 32'h53800000; v2[0] = 32'h3F800000;
    send(2'd0, 16'hFFFF, 4'h8);
    @(negedge clk);
    chk("t5_shift_sat", 128'(out_align_shift[5:0]), 128'(27));
    drain();

    // masked group skipping
    fill_rand();
    bs = beats_seen;
    send(2'd2, 16'h00F0, 4'h9);
    @(negedge clk);
    chk("t6_first_group", 128'({out_group, out_last}), 128'({2'd1, 1'b0}));
    drain();
    chk("t6_beats", 128'(beats_seen - bs), 128'(2));
    fill_rand();
    bs = beats_seen;
    send(2'd0, 16'h0000, 4'hA);
    @(negedge clk);
    chk("t6_zero_mask_group", 128'({out_group, out_last}), 128'({2'd3, 1'b1}));
    drain();
    chk("t6_zero_mask_beats", 128'(beats_seen - bs), 128'(1));

    // backpressure hold
    out_ready = 1'b0;
    fill_rand();
    send(2'd1, 16'hFFFF, 4'hB);
    @(negedge clk);
    snap = outs();
    chk("hold_valid", 128'(out_valid), 128'(1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (outs() !== snap) begin
        errors++;
        $display("FAIL hold_stable: got %0h, expected %0h", outs(), snap);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // back-to-back vectors
    beat_cycles.delete();
    fill_rand();
    send(2'd0, 16'hFFFF, 4'hC);
    acc_a = last_accept;
    fill_rand();
    send(2'd3, 16'hFFFF, 4'hD);
    chk("b2b_accept_gap", 128'(last_accept - acc_a), 128'(4));
    drain();
    chk("b2b_beats", 128'(beat_cycles.size()), 128'(8));
    okc = 1;
    for (int i = 1; i < beat_cycles.size(); i++)
      if (beat_cycles[i] != beat_cycles[i-1] + 1) okc = 0;
    chk("b2b_no_bubble", 128'(okc), 128'(1));

    // reset mid-vector
    fill_rand();
    send(2'd0, 16'hFFFF, 4'hE);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst_valid_drop", 128'(out_valid), 128'(0));
    exp_q.delete();
    bs = beats_seen;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_beats", 128'(beats_seen - bs), 128'(0));
    chk("rst_idle_valid", 128'(out_valid), 128'(0));

    // randomized traffic with random backpressure
    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      fill_rand();
      send(2'($urandom_range(0, 3)), gen_mask(), 4'($urandom));
    end
    drain();
    rand_ready = 0;
    out_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
